line_rasterizer: RTL and testbench

- Consumer end of the line-register queue: pops queued line segments (start/end coordinates plus colour) written by the vector generator core.
- Rasterizes each segment with integer Bresenham at one pixel per clock.
- Emits pixel writes to the framebuffer writer under a valid/ready handshake.
- Sits in the fast pixel-clock domain, between the queue's read side and the framebuffer.

---
 rtl/line_rasterizer.sv | 186 ++++++++++++++++++
 tb/tb_line_rasterizer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_rasterizer.sv
// Bresenham line rasterizer: pops one segment at a time from a show-ahead
// line queue and emits one pixel per clock to the framebuffer writer.
// Pixels outside [0,XMAX)x[0,YMAX) are stepped over without a write.
module line_rasterizer #(
    parameter int unsigned XMAX = 640,
    parameter int unsigned YMAX = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] lineStartX,
    input  logic [10:0] lineEndX,
    input  logic [10:0] lineStartY,
    input  logic [10:0] lineEndY,
    input  logic [2:0]  lineColor,
    input  logic        lineEmpty,
    output logic        lineRead,
    output logic [10:0] pixX,
    output logic [10:0] pixY,
    output logic [2:0]  pixColor,
    output logic        pixWrite,
    input  logic        pixReady,
    output logic        lineDone,
    output logic        busy
);

    localparam logic [11:0] L_XLIM = 12'(XMAX);
    localparam logic [11:0] L_YLIM = 12'(YMAX);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSetup = 2'd1,
        StDraw  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_d;

    // Current pixel position doubles as the latched start point until SETUP.
    logic [10:0]         r_x;
    logic [10:0]         r_y;
    logic [10:0]         r_x1;
    logic [10:0]         r_y1;
    logic [2:0]          r_color;
    logic signed [11:0]  r_dx;
    logic signed [11:0]  r_dy;
    logic                r_sx_neg;
    logic                r_sy_neg;
    logic signed [13:0]  r_err;

    logic [11:0]         w_dx_abs;
    logic [11:0]         w_dy_abs;
    logic signed [13:0]  w_dx_ext;
    logic signed [13:0]  w_dy_ext;
    logic signed [13:0]  w_e2;
    logic                w_step_x;
    logic                w_step_y;
    logic signed [13:0]  w_err_next;
    logic [10:0]         w_x_inc;
    logic [10:0]         w_y_inc;
    logic                w_clip;
    logic                w_at_end;
    logic                w_consumed;

    // Bresenham step terms and the pixel-consumed condition.
    always_comb begin
        w_dx_abs   = (r_x1 >= r_x) ? {1'b0, r_x1 - r_x} : {1'b0, r_x - r_x1};
        w_dy_abs   = (r_y1 >= r_y) ? {1'b0, r_y1 - r_y} : {1'b0, r_y - r_y1};
        w_dx_ext   = {{2{r_dx[11]}}, r_dx};
        w_dy_ext   = {{2{r_dy[11]}}, r_dy};
        w_e2       = r_err <<< 1;
        w_step_x   = (w_e2 >= w_dy_ext);
        w_step_y   = (w_e2 <= w_dx_ext);
        // Both adjustments start from the pre-update error.
        w_err_next = r_err + (w_step_x ? w_dy_ext : 14'sd0)
                           + (w_step_y ? w_dx_ext : 14'sd0);
        w_x_inc    = r_sx_neg ? 11'h7ff : 11'h001;
        w_y_inc    = r_sy_neg ? 11'h7ff : 11'h001;
        w_clip     = ({1'b0, r_x} >= L_XLIM) || ({1'b0, r_y} >= L_YLIM);
        w_at_end   = (r_x == r_x1) && (r_y == r_y1);
        // A clipped pixel never waits on the framebuffer.
        w_consumed = (r_state == StDraw) && (w_clip || pixReady);
    end

    // Next-state decode and handshake strobes.
    always_comb begin
        w_state_d = r_state;
        lineRead  = 1'b0;
        lineDone  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!lineEmpty) begin
                    lineRead  = 1'b1;
                    w_state_d = StSetup;
                end
            end
            StSetup: begin
                if (r_color == 3'd0) begin
                    lineDone  = 1'b1;
                    w_state_d = StIdle;
                end else begin
                    w_state_d = StDraw;
                end
            end
            StDraw: begin
                if (w_consumed && w_at_end) begin
                    lineDone  = 1'b1;
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
        // Suppress strobes while in reset so no queue entry is lost.
        if (rst) begin
            lineRead = 1'b0;
            lineDone = 1'b0;
        end
    end

    // Pixel port is a direct view of the current Bresenham position.
    always_comb begin
        pixX     = r_x;
        pixY     = r_y;
        pixColor = r_color;
        pixWrite = (r_state == StDraw) && !w_clip && !rst;
        busy     = (r_state != StIdle);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Segment latch, setup arithmetic and per-pixel stepping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x      <= '0;
            r_y      <= '0;
            r_x1     <= '0;
            r_y1     <= '0;
            r_color  <= '0;
            r_dx     <= '0;
            r_dy     <= '0;
            r_sx_neg <= 1'b0;
            r_sy_neg <= 1'b0;
            r_err    <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (!lineEmpty) begin
                        r_x     <= lineStartX;
                        r_y     <= lineStartY;
                        r_x1    <= lineEndX;
                        r_y1    <= lineEndY;
                        r_color <= lineColor;
                    end
                end
                StSetup: begin
                    if (r_color != 3'd0) begin
                        r_dx     <= w_dx_abs;
                        r_dy     <= -w_dy_abs;
                        r_sx_neg <= !(r_x < r_x1);
                        r_sy_neg <= !(r_y < r_y1);
                        r_err    <= {2'b00, w_dx_abs} - {2'b00, w_dy_abs};
                    end
                end
                StDraw: begin
                    if (w_consumed && !w_at_end) begin
                        r_err <= w_err_next;
                        if (w_step_x) begin
                            r_x <= r_x + w_x_inc;
                        end
                        if (w_step_y) begin
                            r_y <= r_y + w_y_inc;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_line_rasterizer.sv
// Self-checking bench for line_rasterizer: a queue model feeds segments, an
// integer Bresenham reference predicts the accepted pixel stream.
module tb_line_rasterizer;

    localparam int XMAX = 640;
    localparam int YMAX = 480;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] lineStartX, lineEndX, lineStartY, lineEndY;
    logic [2:0]  lineColor;
    logic        lineEmpty;
    logic        lineRead;
    logic [10:0] pixX, pixY;
    logic [2:0]  pixColor;
    logic        pixWrite;
    logic        pixReady;
    logic        lineDone;
    logic        busy;

    line_rasterizer #(.XMAX(XMAX), .YMAX(YMAX)) dut (
        .clk        (clk),
        .rst        (rst),
        .lineStartX (lineStartX),
        .lineEndX   (lineEndX),
        .lineStartY (lineStartY),
        .lineEndY   (lineEndY),
        .lineColor  (lineColor),
        .lineEmpty  (lineEmpty),
        .lineRead   (lineRead),
        .pixX       (pixX),
        .pixY       (pixY),
        .pixColor   (pixColor),
        .pixWrite   (pixWrite),
        .pixReady   (pixReady),
        .lineDone   (lineDone),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x0; int y0; int x1; int y1; int c;
    } seg_t;

    typedef struct {
        int x0; int y0; int x1; int y1; int c;
        int n_wr; int n_draw;
    } vec_t;

    seg_t seg_q[$];
    int   wr_q[$];
    int   exp_q[$];
    int   wr_cyc[$];
    int   rd_cyc[$];
    int   done_cyc[$];
    int   cyc;
    int   busy_cnt;
    int   total;
    int   bad;
    int   stall_idx;
    int   stall_left;
    int   stall_seen;
    bit   chk_hold;
    int   hold_x;
    int   hold_y;
    bit   rand_ready;

    function automatic int pk(int x, int y, int c);
        return x * 65536 + y * 8 + c;
    endfunction

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference: walk the segment with plain integer Bresenham.
    task automatic model_seg(input seg_t s);
        int x, y, dx, dy, sx, sy, err, e2;
        if (s.c == 0) return;
        x   = s.x0;
        y   = s.y0;
        dx  = (s.x1 > s.x0) ? s.x1 - s.x0 : s.x0 - s.x1;
        dy  = -((s.y1 > s.y0) ? s.y1 - s.y0 : s.y0 - s.y1);
        sx  = (s.x0 < s.x1) ? 1 : -1;
        sy  = (s.y0 < s.y1) ? 1 : -1;
        err = dx + dy;
        forever begin
            if (x < XMAX && y < YMAX) exp_q.push_back(pk(x, y, s.c));
            if (x == s.x1 && y == s.y1) break;
            e2 = 2 * err;
            if (e2 >= dy) begin err += dy; x += sx; end
            if (e2 <= dx) begin err += dx; y += sy; end
        end
    endtask

    task automatic drive_head();
        if (seg_q.size() == 0) begin
            lineEmpty = 1'b1;
        end else begin
            lineEmpty  = 1'b0;
            lineStartX = 11'(seg_q[0].x0);
            lineStartY = 11'(seg_q[0].y0);
            lineEndX   = 11'(seg_q[0].x1);
            lineEndY   = 11'(seg_q[0].y1);
            lineColor  = 3'(seg_q[0].c);
        end
    endtask

    task automatic clear_logs();
        wr_q.delete(); exp_q.delete(); wr_cyc.delete();
        rd_cyc.delete(); done_cyc.delete();
        busy_cnt = 0; stall_seen = 0;
    endtask

    // One clock: sample at negedge, pop/update inputs just after posedge.
    task automatic step();
        bit saw_read;
        @(negedge clk);
        cyc++;
        saw_read = lineRead;
        if (lineRead) rd_cyc.push_back(cyc);
        if (lineDone) done_cyc.push_back(cyc);
        if (busy) busy_cnt++;
        if (pixWrite && pixReady) begin
            wr_q.push_back(pk(int'(pixX), int'(pixY), int'(pixColor)));
            wr_cyc.push_back(cyc);
        end
        if (chk_hold && pixWrite && !pixReady) begin
            stall_seen++;
            check("stall_hold_x", int'(pixX), hold_x);
            check("stall_hold_y", int'(pixY), hold_y);
        end
        @(posedge clk);
        #1;
        if (saw_read && seg_q.size() > 0) void'(seg_q.pop_front());
        drive_head();
        if (stall_left > 0 && wr_q.size() == stall_idx) begin
            pixReady = 1'b0;
            stall_left--;
        end else if (rand_ready) begin
            pixReady = ($urandom_range(3) != 0);
        end else begin
            pixReady = 1'b1;
        end
    endtask

    task automatic run_idle(input int budget);
        int n = 0;
        drive_head();
        while ((seg_q.size() != 0 || busy) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            total++; bad++;
            $display("FAIL run_timeout: got %0d cycles, expected fewer than %0d", n, budget);
        end
    endtask

    task automatic compare_writes(input string name);
        int n;
        check({name, "_count"}, wr_q.size(), exp_q.size());
        n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({name, "_pix"}, wr_q[i], exp_q[i]);
    endtask

    vec_t vecs[8];
    seg_t s;

    initial begin
        total = 0; bad = 0; cyc = 0;
        stall_idx = 0; stall_left = 0; chk_hold = 0; hold_x = 0; hold_y = 0;
        rand_ready = 0;
        rst = 1'b1; pixReady = 1'b1; lineEmpty = 1'b1;
        lineStartX = '0; lineEndX = '0; lineStartY = '0; lineEndY = '0; lineColor = '0;

        vecs[0] = '{10, 5, 14, 5, 3, 5, 5};
        vecs[1] = '{20, 20, 17, 14, 7, 7, 7};
        vecs[2] = '{637, 0, 642, 0, 2, 3, 6};
        vecs[3] = '{2, 2, 2, 2, 1, 1, 1};
        vecs[4] = '{5, 5, 100, 7, 0, 0, 0};
        vecs[5] = '{0, 0, 3, 3, 4, 4, 4};
        vecs[6] = '{630, 470, 645, 485, 5, 10, 16};
        vecs[7] = '{100, 50, 90, 53, 6, 11, 11};

        // Reset state.
        step(); step();
        rst = 1'b0;
        #3;
        check("rst_lineRead", int'(lineRead), 0);
        check("rst_pixWrite", int'(pixWrite), 0);
        check("rst_pixX", int'(pixX), 0);
        check("rst_pixY", int'(pixY), 0);
        check("rst_pixColor", int'(pixColor), 0);
        check("rst_lineDone", int'(lineDone), 0);
        check("rst_busy", int'(busy), 0);

        // Table-driven single segments.
        for (int i = 0; i < 8; i++) begin
            clear_logs();
            s = '{vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1, vecs[i].c};
            seg_q.push_back(s);
            model_seg(s);
            run_idle(200);
            step();
            check("vec_nwr", wr_q.size(), vecs[i].n_wr);
            compare_writes("vec");
            check("vec_draw_cycles", busy_cnt - 1, vecs[i].n_draw);
            check("vec_reads", rd_cyc.size(), 1);
            check("vec_dones", done_cyc.size(), 1);
            check("vec_idle_busy", int'(busy), 0);
            if (wr_cyc.size() > 0 && rd_cyc.size() > 0)
                check("vec_latency", wr_cyc[0] - rd_cyc[0], 2);
            if (vecs[i].c != 0 && vecs[i].x1 < XMAX && vecs[i].y1 < YMAX &&
                wr_cyc.size() > 0 && done_cyc.size() > 0)
                check("vec_done_with_last", done_cyc[0], wr_cyc[wr_cyc.size() - 1]);
        end

        // Backpressure: 4-cycle stall on the second pixel.
        clear_logs();
        s = '{0, 0, 3, 3, 5};
        seg_q.push_back(s);
        model_seg(s);
        stall_idx = 1; stall_left = 4; chk_hold = 1; hold_x = 1; hold_y = 1;
        run_idle(200);
        step();
        chk_hold = 0;
        compare_writes("bp");
        check("bp_stall_cycles", stall_seen, 4);

        // Blank segment followed by a degenerate one.
        clear_logs();
        seg_q.push_back('{9, 9, 30, 40, 0});
        s = '{2, 2, 2, 2, 1};
        seg_q.push_back(s);
        model_seg(s);
        run_idle(200);
        step();
        compare_writes("b2b");
        check("b2b_reads", rd_cyc.size(), 2);
        check("b2b_dones", done_cyc.size(), 2);
        if (rd_cyc.size() == 2 && done_cyc.size() >= 1) begin
            check("b2b_blank_done_in_setup", done_cyc[0], rd_cyc[0] + 1);
            check("b2b_second_pop", rd_cyc[1], done_cyc[0] + 1);
        end

        // Reset in the middle of a line.
        clear_logs();
        seg_q.push_back('{0, 0, 9, 0, 3});
        exp_q.push_back(pk(0, 0, 3));
        exp_q.push_back(pk(1, 0, 3));
        drive_head();
        for (int n = 0; n < 50 && wr_q.size() < 2; n++) step();
        rst = 1'b1; pixReady = 1'b0;
        step();
        rst = 1'b0; pixReady = 1'b1;
        #3;
        check("mid_rst_lineRead", int'(lineRead), 0);
        check("mid_rst_pixWrite", int'(pixWrite), 0);
        check("mid_rst_pixX", int'(pixX), 0);
        check("mid_rst_pixY", int'(pixY), 0);
        check("mid_rst_pixColor", int'(pixColor), 0);
        check("mid_rst_lineDone", int'(lineDone), 0);
        check("mid_rst_busy", int'(busy), 0);
        for (int n = 0; n < 5; n++) step();
        check("mid_rst_no_more_pix", wr_q.size(), 2);
        s = '{40, 10, 43, 12, 6};
        seg_q.push_back(s);
        model_seg(s);
        run_idle(200);
        step();
        compare_writes("mid_rst");

        // Randomized segments with random backpressure.
        clear_logs();
        rand_ready = 1;
        for (int i = 0; i < 40; i++) begin
            s.x0 = $urandom_range(700, 0);
            s.y0 = $urandom_range(520, 0);
            s.x1 = s.x0 + $urandom_range(24, 0) - 12;
            s.y1 = s.y0 + $urandom_range(24, 0) - 12;
            if (s.x1 < 0) s.x1 = 0;
            if (s.y1 < 0) s.y1 = 0;
            s.c = $urandom_range(7, 0);
            seg_q.push_back(s);
            model_seg(s);
        end
        run_idle(20000);
        step();
        rand_ready = 0;
        compare_writes("rand");
        check("rand_reads", rd_cyc.size(), 40);
        check("rand_dones", done_cyc.size(), 40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
